// File: rtl/pong_pkg.sv
// Shared constants for the pong core: match FSM state codes, winner encodings and defaults.
package pong_pkg;

  localparam int unsigned WIN_SCORE_DEF = 10;
  localparam int unsigned SCORE_W_DEF   = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSED    = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a debounced button level; clr drops the history like a reset.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     level_q <= 1'b0;
    else if (clr) level_q <= 1'b0;
    else          level_q <= level;
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Match-level controller for the pong core: scores, win detection, serve/pause/over sequencing
// and the ball engine run/reset strobes.
module game_flow_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned OVER_HOLD   = 180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause_btn,
  input  logic               clear,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               paused,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int unsigned TIMER_W = $clog2(max_u(SERVE_DELAY, OVER_HOLD) + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [TIMER_W-1:0] OVER_LAST  = TIMER_W'(OVER_HOLD - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > (1 << SCORE_W) - 1) begin : g_bad_win
    $error("game_flow_ctrl: WIN_SCORE must be in 1 .. 2**SCORE_W-1");
  end
  if (SERVE_DELAY == 0 || OVER_HOLD == 0) begin : g_bad_timer
    $error("game_flow_ctrl: SERVE_DELAY and OVER_HOLD must be >= 1");
  end

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  logic               pause_rise;
  logic [2:0]         state_q, state_d;
  logic               saved_q, saved_d;  // 1 = paused out of PLAY, 0 = out of SERVE
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] s1_d, s2_d, s1_goal, s2_goal;
  logic [1:0]         win_d;
  logic               p1_win, p2_win;

  edge_rise u_pause_edge (
    .clk    (clk),
    .rst    (rst),
    .clr    (clear),
    .level  (pause_btn),
    .rise_c (pause_rise)
  );

  // Next-state, timer, score and winner logic.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    timer_d = timer_q;
    s1_d    = score_p1;
    s2_d    = score_p2;
    win_d   = winner;
    s1_goal = goal_p1 ? sat_inc(score_p1) : score_p1;
    s2_goal = goal_p2 ? sat_inc(score_p2) : score_p2;
    p1_win  = (s1_goal >= WIN_VAL);
    p2_win  = (s2_goal >= WIN_VAL);

    if (clear) begin
      state_d = ST_IDLE;
      saved_d = 1'b0;
      timer_d = '0;
      s1_d    = '0;
      s2_d    = '0;
      win_d   = WINNER_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SERVE;
            timer_d = '0;
            s1_d    = '0;
            s2_d    = '0;
            win_d   = WINNER_NONE;
          end
        end
        ST_SERVE: begin
          if (pause_rise) begin
            state_d = ST_PAUSED;
            saved_d = 1'b0;
          end else if (frame_tick) begin
            if (timer_q == SERVE_LAST) begin
              state_d = ST_PLAY;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
        end
        ST_PLAY: begin
          // A goal in the same cycle as a pause press wins; the press is dropped.
          if (goal_p1 || goal_p2) begin
            s1_d    = s1_goal;
            s2_d    = s2_goal;
            timer_d = '0;
            if (p1_win || p2_win) begin
              state_d = ST_GAME_OVER;
              win_d   = (p1_win && p2_win) ? WINNER_DRAW : (p1_win ? WINNER_P1 : WINNER_P2);
            end else begin
              state_d = ST_SERVE;
            end
          end else if (pause_rise) begin
            state_d = ST_PAUSED;
            saved_d = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (pause_rise) state_d = saved_q ? ST_PLAY : ST_SERVE;
        end
        ST_GAME_OVER: begin
          if (frame_tick) begin
            if (timer_q == OVER_LAST) begin
              state_d = ST_IDLE;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, counters and registered strobes decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      saved_q    <= 1'b0;
      timer_q    <= '0;
      score_p1   <= '0;
      score_p2   <= '0;
      winner     <= WINNER_NONE;
      ball_run   <= 1'b0;
      ball_reset <= 1'b1;
      paused     <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      timer_q    <= timer_d;
      score_p1   <= s1_d;
      score_p2   <= s2_d;
      winner     <= win_d;
      ball_run   <= (state_d == ST_PLAY);
      ball_reset <= (state_d == ST_IDLE) || (state_d == ST_SERVE);
      paused     <= (state_d == ST_PAUSED);
      game_over  <= (state_d == ST_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

  localparam int K_IDLE   = 0;
  localparam int K_SERVE  = 1;
  localparam int K_PLAY   = 2;
  localparam int K_PAUSED = 3;
  localparam int K_OVER   = 4;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       run;
    logic       brst;
    logic       pau;
    logic       over;
    logic [1:0] win;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, start, pause_btn, clear, goal_p1, goal_p2;
  logic [3:0] score_p1, score_p2;
  logic       ball_run, ball_reset, paused, game_over;
  logic [1:0] winner;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    e1 = 0, e2 = 0;
  logic [1:0] ew = 2'b00;

  game_flow_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .pause_btn  (pause_btn),
    .clear      (clear),
    .goal_p1    (goal_p1),
    .goal_p2    (goal_p2),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .paused     (paused),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  function automatic obs_t mk(input int k);
    obs_t o;
    o.s1   = 4'(e1);
    o.s2   = 4'(e2);
    o.run  = (k == K_PLAY);
    o.brst = (k == K_IDLE) || (k == K_SERVE);
    o.pau  = (k == K_PAUSED);
    o.over = (k == K_OVER);
    o.win  = ew;
    return o;
  endfunction

  task automatic step(input logic tk, st, pb, g1, g2, cl);
    frame_tick = tk; start = st; pause_btn = pb; goal_p1 = g1; goal_p2 = g2; clear = cl;
    @(posedge clk);
    #1;
  endtask

  // Push the expectation, drive one cycle, then pop and compare the DUT outputs.
  task automatic cyc(input string tag, input int k, input logic tk, st, pb, g1, g2, cl);
    obs_t  e;
    obs_t  o;
    string t;
    exp_q.push_back(mk(k));
    tag_q.push_back(tag);
    step(tk, st, pb, g1, g2, cl);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {score_p1, score_p2, ball_run, ball_reset, paused, game_over, winner};
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", t, o, e);
    end
  endtask

  task automatic tick_n(input int n, input logic pb);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, pb, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic serve_out(input string tag);
    tick_n(59, 1'b0);
    cyc({tag, "_59ticks"}, K_SERVE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc({tag, "_60ticks"}, K_PLAY,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goal_serve(input logic g1, input logic g2);
    e1 += int'(g1);
    e2 += int'(g2);
    cyc("goal", K_SERVE, 1'b0, 1'b0, 1'b0, g1, g2, 1'b0);
    serve_out("reserve");
  endtask

  initial begin
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("reset_state", K_IDLE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("idle_hold", K_IDLE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Serve timing, then reach 3:2 in PLAY and hit the async reset.
    cyc("start", K_SERVE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    serve_out("first_serve");
    goal_serve(1'b1, 1'b0);
    goal_serve(1'b0, 1'b1);
    goal_serve(1'b1, 1'b0);
    goal_serve(1'b1, 1'b0);
    goal_serve(1'b0, 1'b1);
    e1 = 0; e2 = 0; ew = 2'b00;
    rst = 1'b0;
    cyc("async_rst_mid_play", K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Player 1 wins 10:0, GAME_OVER hold, scores retained in IDLE.
    cyc("start2", K_SERVE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    serve_out("serve2");
    for (int i = 0; i < 9; i++) goal_serve(1'b1, 1'b0);
    e1 = 10; ew = 2'b01;
    cyc("win_p1", K_OVER, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("over_ignores_start_pause", K_OVER, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(178, 1'b0);
    cyc("over_179ticks", K_OVER, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("over_180ticks", K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle_ignores_goal", K_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 9:9 then simultaneous goals -> draw; clear out of GAME_OVER.
    e1 = 0; e2 = 0; ew = 2'b00;
    cyc("start3_clears", K_SERVE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    serve_out("serve3");
    for (int i = 0; i < 9; i++) begin
      goal_serve(1'b1, 1'b0);
      goal_serve(1'b0, 1'b1);
    end
    e1 = 10; e2 = 10; ew = 2'b11;
    cyc("draw", K_OVER, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e1 = 0; e2 = 0; ew = 2'b00;
    cyc("clear_in_over", K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pause in SERVE at timer 20, frozen through ticks and a goal, resume keeps timer.
    cyc("start4", K_SERVE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(20, 1'b0);
    cyc("pause_serve", K_PAUSED, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(25, 1'b1);
    cyc("paused_ignores_goal", K_PAUSED, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_n(24, 1'b1);
    cyc("paused_held_btn", K_PAUSED, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("resume_serve", K_SERVE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(38, 1'b1);
    cyc("resume_39ticks_held", K_SERVE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("resume_40ticks", K_PLAY, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause out of PLAY returns to PLAY.
    cyc("pause_play", K_PAUSED, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("paused_release", K_PAUSED, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("resume_play", K_PLAY, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("play_release", K_PLAY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Goal beats a simultaneous pause rise; clear mid-SERVE.
    e2 = 1;
    cyc("goal_beats_pause", K_SERVE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("pause_discarded", K_SERVE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_n(10, 1'b0);
    e1 = 0; e2 = 0;
    cyc("clear_mid_serve", K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("idle_after_clear", K_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
